// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, constants and the fetch-queue entry type for the
//            RISC-V pipeline core.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    // Canonical no-op (addi x0, x0, 0), used by later stages for bubbles.
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of fetch entries. Flush beats push; pops on an
//            empty queue and pushes on a full one are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fetch_entry_t     r_mem [DEPTH];

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = push && !flush && (!w_full || w_do_pop);

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage. Prefetches from a synchronous
//            instruction memory into a small queue and hands {instr, pc,
//            pc+4} to decode over valid/ready. Redirects flush the queue and
//            kill the read in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         IM_en,
    output logic [XLEN-1:0]              IM_address,
    input  logic [31:0]                  IM_out,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [31:0]                  id_instr,
    output logic [XLEN-1:0]              id_pc,
    output logic [XLEN-1:0]              id_pc4,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_inflight_pc;
    logic             r_inflight;

    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic [CNT_W-1:0] w_count;
    logic [OCC_W-1:0] w_occupancy;
    logic             w_pop;
    logic             w_issue;
    logic             w_unused_lsbs;

    // Redirect targets are word aligned; the two low bits carry no meaning.
    assign w_unused_lsbs = ^redirect_pc[1:0];

    assign id_valid = (w_count != '0);
    assign w_pop    = id_valid && id_ready;

    // Slots already claimed once this cycle's pop retires: queued entries
    // plus the response arriving now. Issue only if one is still free.
    assign w_occupancy = {1'b0, w_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_issue     = !rst && !redirect_valid && (w_occupancy < OCC_W'(DEPTH));

    assign IM_en      = w_issue;
    assign IM_address = r_fetch_pc;

    assign w_push_data = '{pc: r_inflight_pc, instr: IM_out};

    // A redirect flushes the queue; flush wins over the response push, so
    // the read in flight during the redirect cycle is dropped here.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .count     (w_count)
    );

    assign fifo_count = w_count;
    assign id_instr   = id_valid ? w_head.instr : '0;
    assign id_pc      = id_valid ? w_head.pc : '0;
    assign id_pc4     = id_valid ? (w_head.pc + XLEN'(4)) : '0;

    // Fetch PC and in-flight tracking; a redirect suppresses issue, which
    // also clears the in-flight bit for the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench. Two instances (DEPTH=2/RESET_PC=0 and
//            DEPTH=4/RESET_PC=0x80) share stimulus; a queue-based reference
//            model checks both every cycle, with directed sequences on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        im_en    [2];
    logic [31:0] im_addr  [2];
    logic [31:0] im_out   [2];
    logic        id_valid [2];
    logic [31:0] id_instr [2];
    logic [31:0] id_pc    [2];
    logic [31:0] id_pc4   [2];
    logic [1:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic [31:0] cnt      [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign cnt[0] = {30'd0, cnt_a};
    assign cnt[1] = {29'd0, cnt_b};

    fetch_unit #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .IM_en(im_en[0]), .IM_address(im_addr[0]), .IM_out(im_out[0]),
        .id_valid(id_valid[0]), .id_ready(id_ready), .id_instr(id_instr[0]),
        .id_pc(id_pc[0]), .id_pc4(id_pc4[0]), .fifo_count(cnt_a)
    );

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h80)) dut_b (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .IM_en(im_en[1]), .IM_address(im_addr[1]), .IM_out(im_out[1]),
        .id_valid(id_valid[1]), .id_ready(id_ready), .id_instr(id_instr[1]),
        .id_pc(id_pc[1]), .id_pc4(id_pc4[1]), .fifo_count(cnt_b)
    );

    // Synchronous instruction memory: word at addr is addr ^ K; junk when idle.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            im_out[d] <= im_en[d] ? (im_addr[d] ^ K) : $urandom;
        end
    end

    function automatic int dep(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] rpc(input int d);
        return (d == 0) ? 32'h0 : 32'h80;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq [2][$];
    bit          m_inf [2];
    logic [31:0] m_ipc [2];
    logic [31:0] m_fpc [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int          sz;
            bit          pop;
            bit          en;
            logic [31:0] hpc;
            sz  = mq[d].size();
            pop = (sz > 0) && id_ready;
            en  = !rst && !redirect_valid && ((sz + (m_inf[d] ? 1 : 0) - (pop ? 1 : 0)) < dep(d));
            hpc = (sz > 0) ? mq[d][0] : 32'h0;
            chk($sformatf("m%0d_IM_en", d), {31'd0, im_en[d]}, {31'd0, en});
            if (en) chk($sformatf("m%0d_IM_address", d), im_addr[d], m_fpc[d]);
            chk($sformatf("m%0d_id_valid", d), {31'd0, id_valid[d]}, (sz > 0) ? 32'd1 : 32'd0);
            chk($sformatf("m%0d_fifo_count", d), cnt[d], 32'(sz));
            chk($sformatf("m%0d_id_pc", d), id_pc[d], hpc);
            chk($sformatf("m%0d_id_instr", d), id_instr[d], (sz > 0) ? (hpc ^ K) : 32'h0);
            chk($sformatf("m%0d_id_pc4", d), id_pc4[d], (sz > 0) ? (hpc + 32'd4) : 32'h0);
            // advance to the state after the coming rising edge
            if (rst) begin
                mq[d].delete();
                m_inf[d] = 1'b0;
                m_fpc[d] = rpc(d);
            end else begin
                if (pop) void'(mq[d].pop_front());
                if (redirect_valid) begin
                    mq[d].delete();
                    m_inf[d] = 1'b0;
                    m_fpc[d] = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (m_inf[d]) mq[d].push_back(m_ipc[d]);
                    m_inf[d] = en;
                    m_ipc[d] = m_fpc[d];
                    if (en) m_fpc[d] = m_fpc[d] + 32'd4;
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst;
        bit          ready;
        bit          en;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        int          count;
    } vec_t;

    vec_t tbl [8];
    int   issues [2];
    int   got    [2];
    bit   found;
    bit   saw10;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 1};

        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset then streaming with ID always ready (DEPTH=2 instance).
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            rst      = tbl[i].rst;
            id_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d_IM_en", i), {31'd0, im_en[0]}, {31'd0, tbl[i].en});
            chk($sformatf("v%0d_IM_address", i), im_addr[0], tbl[i].addr);
            chk($sformatf("v%0d_id_valid", i), {31'd0, id_valid[0]}, {31'd0, tbl[i].valid});
            chk($sformatf("v%0d_id_pc", i), id_pc[0], tbl[i].pc);
            chk($sformatf("v%0d_id_instr", i), id_instr[0], tbl[i].valid ? (tbl[i].pc ^ K) : 32'h0);
            chk($sformatf("v%0d_id_pc4", i), id_pc4[0], tbl[i].valid ? (tbl[i].pc + 32'd4) : 32'h0);
            chk($sformatf("v%0d_fifo_count", i), cnt[0], 32'(tbl[i].count));
        end

        // Stall: ID not ready for 10 cycles straight after reset.
        step(); rst = 1'b1; id_ready = 1'b0; @(negedge clk);
        step(); rst = 1'b0;
        issues[0] = 0; issues[1] = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (im_en[d]) issues[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("stall%0d_issues", d), 32'(issues[d]), 32'(dep(d)));
            chk($sformatf("stall%0d_count", d), cnt[d], 32'(dep(d)));
            chk($sformatf("stall%0d_IM_en", d), {31'd0, im_en[d]}, 32'd0);
        end

        // Release: entries leave in order with no loss or duplication.
        step(); id_ready = 1'b1;
        got[0] = 0; got[1] = 0;
        for (int c = 0; c < 40 && (got[0] < 8 || got[1] < 8); c++) begin
            if (c > 0) step();
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (id_valid[d] && got[d] < 8) begin
                    chk($sformatf("drain%0d_pc%0d", d, got[d]), id_pc[d], rpc(d) + 32'(4 * got[d]));
                    got[d]++;
                end
            end
        end
        for (int d = 0; d < 2; d++) chk($sformatf("drain%0d_n", d), 32'(got[d]), 32'd8);

        // Redirect to 0x100 while the read of 0x10 is in flight.
        step(); rst = 1'b1; @(negedge clk);
        step(); rst = 1'b0; id_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (im_en[0] && im_addr[0] == 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        chk("kill_found_0x10", {31'd0, found}, 32'd1);
        saw10 = 1'b0;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h100; @(negedge clk);
        chk("kill_R_IM_en", {31'd0, im_en[0]}, 32'd0);
        if (id_valid[0] && id_pc[0] == 32'h10) saw10 = 1'b1;
        step(); redirect_valid = 1'b0; @(negedge clk);
        chk("kill_R1_count", cnt[0], 32'd0);
        chk("kill_R1_IM_en", {31'd0, im_en[0]}, 32'd1);
        chk("kill_R1_IM_address", im_addr[0], 32'h100);
        if (id_valid[0] && id_pc[0] == 32'h10) saw10 = 1'b1;
        step(); @(negedge clk);
        chk("kill_R2_id_valid", {31'd0, id_valid[0]}, 32'd0);
        step(); @(negedge clk);
        chk("kill_R3_id_valid", {31'd0, id_valid[0]}, 32'd1);
        chk("kill_R3_id_pc", id_pc[0], 32'h100);
        for (int c = 0; c < 4; c++) begin
            step(); @(negedge clk);
            if (id_valid[0] && id_pc[0] == 32'h10) saw10 = 1'b1;
        end
        chk("kill_0x10_never_seen", {31'd0, saw10}, 32'd0);

        // Unaligned target, then back-to-back redirects.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h102; @(negedge clk);
        chk("unal_R_IM_en", {31'd0, im_en[0]}, 32'd0);
        step(); redirect_valid = 1'b0; @(negedge clk);
        chk("unal_R1_IM_en", {31'd0, im_en[0]}, 32'd1);
        chk("unal_R1_IM_address", im_addr[0], 32'h100);
        step(); step();
        step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); redirect_pc = 32'h300;
        step(); redirect_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (id_valid[0]) begin
                chk("b2b_first_id_pc", id_pc[0], 32'h300);
                found = 1'b1;
                break;
            end
        end
        chk("b2b_found", {31'd0, found}, 32'd1);

        // Reset with a full queue; restart at RESET_PC=0x80 (DEPTH=4 instance).
        step(); id_ready = 1'b0;
        for (int c = 0; c < 10; c++) step();
        @(negedge clk);
        chk("rstfull_count_before", cnt[1], 32'd4);
        step(); rst = 1'b1; @(negedge clk);
        chk("rstfull_R_IM_en", {31'd0, im_en[1]}, 32'd0);
        step(); rst = 1'b0; @(negedge clk);
        chk("rstfull_id_valid", {31'd0, id_valid[1]}, 32'd0);
        chk("rstfull_count", cnt[1], 32'd0);
        chk("rstfull_IM_en", {31'd0, im_en[1]}, 32'd1);
        chk("rstfull_IM_address", im_addr[1], 32'h80);

        // Randomised traffic; the reference model checks every cycle.
        for (int c = 0; c < 600; c++) begin
            step();
            rst            = ($urandom_range(0, 99) < 2);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            id_ready       = ($urandom_range(0, 99) < 65);
        end
        step();
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
